// File: rtl/alu_result_display.sv
// ALU result consumer: captures one result per valid pulse, converts the sign-magnitude
// value to BCD with a 4-cycle shift-add-3 engine and scans it onto a 4-digit display.
module alu_result_display #(
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_TENS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [4:0] R,
    input  logic       SF,
    input  logic       ZF,
    input  logic       DZF,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       sf_led,
    output logic       zf_led,
    output logic       dzf_led
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    // Digit symbols: 0..9 are decimal values, the rest are display glyphs.
    localparam logic [3:0] SYM_MINUS = 4'd10;
    localparam logic [3:0] SYM_BLANK = 4'd11;
    localparam logic [3:0] SYM_E     = 4'd12;
    localparam logic [3:0] SYM_R     = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_bit;
    logic [11:0]      r_shift;
    logic [11:0]      w_shift_adj;
    logic             r_neg;
    logic             r_sf;
    logic             r_zf;
    logic             r_dzf;
    logic [3:0]       r_dig [4];
    logic [3:0]       w_tens_sym;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic             w_wrap;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;

    function automatic logic [6:0] encode(input logic [3:0] sym);
        logic [6:0] code;
        case (sym)
            4'd0:      code = 7'b1000000;
            4'd1:      code = 7'b1111001;
            4'd2:      code = 7'b0100100;
            4'd3:      code = 7'b0110000;
            4'd4:      code = 7'b0011001;
            4'd5:      code = 7'b0010010;
            4'd6:      code = 7'b0000010;
            4'd7:      code = 7'b1111000;
            4'd8:      code = 7'b0000000;
            4'd9:      code = 7'b0010000;
            SYM_MINUS: code = 7'b0111111;
            SYM_E:     code = 7'b0000110;
            SYM_R:     code = 7'b0101111;
            default:   code = 7'b1111111;
        endcase
        return code;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (res_valid) w_state_next = S_CONV;
            S_CONV:  if (r_bit == 2'd3) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        res_ready = ~busy;
    end

    // Double-dabble register: [11:8] tens, [7:4] ones, [3:0] magnitude shifted out MSB-first.
    always_comb begin
        w_shift_adj = r_shift;
        if (r_shift[7:4] >= 4'd5)  w_shift_adj[7:4]  = r_shift[7:4]  + 4'd3;
        if (r_shift[11:8] >= 4'd5) w_shift_adj[11:8] = r_shift[11:8] + 4'd3;
    end

    assign w_tens_sym = (BLANK_TENS && (r_shift[11:8] == 4'd0)) ? SYM_BLANK : r_shift[11:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit   <= 2'd0;
            r_shift <= 12'd0;
            r_neg   <= 1'b0;
            r_sf    <= 1'b0;
            r_zf    <= 1'b0;
            r_dzf   <= 1'b0;
            sf_led  <= 1'b0;
            zf_led  <= 1'b0;
            dzf_led <= 1'b0;
            // NOTE: the four digit registers are plain flops, so they take an explicit reset value.
            for (int i = 0; i < 4; i++) r_dig[i] <= SYM_BLANK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (res_valid) begin
                        r_shift <= {8'd0, R[3:0]};
                        r_neg   <= R[4] & (|R[3:0]);
                        r_sf    <= SF;
                        r_zf    <= ZF;
                        r_dzf   <= DZF;
                        r_bit   <= 2'd0;
                    end
                end
                S_CONV: begin
                    r_shift <= w_shift_adj << 1;
                    r_bit   <= r_bit + 2'd1;
                end
                S_LOAD: begin
                    if (r_dzf) begin
                        r_dig[3] <= SYM_E;
                        r_dig[2] <= SYM_R;
                        r_dig[1] <= SYM_R;
                        r_dig[0] <= SYM_BLANK;
                    end else begin
                        r_dig[3] <= r_neg ? SYM_MINUS : SYM_BLANK;
                        r_dig[2] <= SYM_BLANK;
                        r_dig[1] <= w_tens_sym;
                        r_dig[0] <= r_shift[7:4];
                    end
                    sf_led  <= r_sf;
                    zf_led  <= r_zf;
                    dzf_led <= r_dzf;
                end
                default: ;
            endcase
        end
    end

    // Scan runs free of the FSM; an and seg are both registered from the next index.
    assign w_wrap     = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= 4'b1110;
            r_seg <= 7'h7F;
        end else begin
            r_cnt <= w_wrap ? '0 : (r_cnt + CNT_W'(1));
            r_idx <= w_idx_next;
            r_an  <= ~(4'b0001 << w_idx_next);
            r_seg <= encode(r_dig[w_idx_next]);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a fast scan (SCAN_DIV=4) and tens blanking on.
module tb_alu_result_display;

    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C2 = 7'b0100100;
    localparam logic [6:0] C3 = 7'b0110000;
    localparam logic [6:0] C7 = 7'b1111000;
    localparam logic [6:0] CM = 7'b0111111;
    localparam logic [6:0] CB = 7'b1111111;
    localparam logic [6:0] CE = 7'b0000110;
    localparam logic [6:0] CR = 7'b0101111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [4:0] R = 5'd0;
    logic       SF = 1'b0;
    logic       ZF = 1'b0;
    logic       DZF = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       sf_led;
    logic       zf_led;
    logic       dzf_led;

    int checks = 0;
    int errors = 0;

    alu_result_display #(.SCAN_DIV(4), .BLANK_TENS(1'b1)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
        .R(R), .SF(SF), .ZF(ZF), .DZF(DZF), .busy(busy), .seg(seg), .an(an),
        .sf_led(sf_led), .zf_led(zf_led), .dzf_led(dzf_led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Drives one valid pulse; returns one step after the capture edge (cycle N+1).
    task automatic pulse(input logic [4:0] r, input logic sf, input logic zf, input logic dzf);
        R = r; SF = sf; ZF = zf; DZF = dzf;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    // Collects all four digits by watching the scan for 16 cycles; unseen digits stay X.
    task automatic read_display(output logic [27:0] disp);
        logic [3:0] m;
        disp = 'x;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                m = 4'b0001 << i;
                if (an === ~m) disp[7*i +: 7] = seg;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", res_ready); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b want 1110", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b want 1111111", seg); end
        checks++;
        if ({sf_led, zf_led, dzf_led} !== 3'b000) begin
            errors++; $display("FAIL reset_leds got %b want 000", {sf_led, zf_led, dzf_led});
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (an !== exp_an) begin errors++; $display("FAIL scan_an k=%0d got %b want %b", k, an, exp_an); end
            tick();
        end
    endtask

    task automatic test_positive();
        logic [27:0] disp;
        pulse(5'b00111, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy cycle N+%0d got %b want 1", c, busy); end
            if (c < 5) tick();
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pos_busy cycle N+6 got %b want 0", busy); end
        read_display(disp);
        checks++;
        if (disp !== {CB, CB, CB, C7}) begin errors++; $display("FAIL pos_digits got %h want %h", disp, {CB, CB, CB, C7}); end
    endtask

    task automatic test_negative();
        logic [27:0] disp;
        pulse(5'b11100, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        checks++; if (sf_led !== 1'b0) begin errors++; $display("FAIL neg_led_hold N+5 got %b want 0", sf_led); end
        tick();
        checks++; if (sf_led !== 1'b1) begin errors++; $display("FAIL neg_sf_led N+6 got %b want 1", sf_led); end
        read_display(disp);
        checks++;
        if (disp !== {CM, CB, C1, C2}) begin errors++; $display("FAIL neg_digits got %h want %h", disp, {CM, CB, C1, C2}); end
    endtask

    task automatic test_zero();
        logic [27:0] disp;
        pulse(5'b00000, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        checks++;
        if ({sf_led, zf_led, dzf_led} !== 3'b010) begin
            errors++; $display("FAIL zero_leds got %b want 010", {sf_led, zf_led, dzf_led});
        end
        read_display(disp);
        checks++;
        if (disp !== {CB, CB, CB, C0}) begin errors++; $display("FAIL zero_digits got %h want %h", disp, {CB, CB, CB, C0}); end
        pulse(5'b10000, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        read_display(disp);
        checks++;
        if (disp !== {CB, CB, CB, C0}) begin errors++; $display("FAIL negzero_digits got %h want %h", disp, {CB, CB, CB, C0}); end
    endtask

    task automatic test_div_zero();
        logic [27:0] disp;
        pulse(5'b00000, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        checks++; if (dzf_led !== 1'b1) begin errors++; $display("FAIL dzf_led got %b want 1", dzf_led); end
        read_display(disp);
        checks++;
        if (disp !== {CE, CR, CR, CB}) begin errors++; $display("FAIL dzf_digits got %h want %h", disp, {CE, CR, CR, CB}); end
    endtask

    task automatic test_back_to_back();
        logic [27:0] disp;
        pulse(5'b00011, 1'b0, 1'b0, 1'b0);
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready N+1 got %b want 0", res_ready); end
        tick();
        pulse(5'b01001, 1'b0, 1'b0, 1'b0);
        for (int c = 3; c <= 5; c++) begin
            checks++;
            if (res_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready N+%0d got %b want 0", c, res_ready); end
            if (c < 5) tick();
        end
        tick();
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready N+6 got %b want 1", res_ready); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_restart got %b want 0", busy); end
        read_display(disp);
        checks++;
        if (disp !== {CB, CB, CB, C3}) begin errors++; $display("FAIL b2b_digits got %h want %h", disp, {CB, CB, CB, C3}); end
    endtask

    task automatic test_reset_mid_conv();
        logic [27:0] disp;
        pulse(5'b10101, 1'b1, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        R = 5'b01001;
        res_valid = 1'b1;
        tick();
        rst = 1'b0;
        res_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL midrst_an got %b want 1110", an); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_dropped_valid got %b want 0", busy); end
        repeat (6) tick();
        checks++;
        if ({sf_led, zf_led, dzf_led} !== 3'b000) begin
            errors++; $display("FAIL midrst_leds got %b want 000", {sf_led, zf_led, dzf_led});
        end
        read_display(disp);
        checks++;
        if (disp !== {CB, CB, CB, CB}) begin errors++; $display("FAIL midrst_digits got %h want %h", disp, {CB, CB, CB, CB}); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_positive();
        test_negative();
        test_zero();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
